jtopl_lfo: RTL and testbench

JTOPL_LFO -- requirements
Module: jtopl_lfo

---
 rtl/jtopl_lfo.sv | 66 ++++++
 tb/tb_jtopl_lfo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jtopl_lfo.sv
// rtl/jtopl_lfo.sv - OPL LFO: vibrato phase (lfo_mod) and tremolo attenuation (am).
// Define JTOPL_LFO_TEST_EN to let lfo_rst hold the LFO counters at zero.
module jtopl_lfo #(
  parameter int PRESCALE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic       zero,
  input  logic       am_dep,
  input  logic       lfo_rst,
  output logic [6:0] lfo_mod,
  output logic [4:0] am
);

  logic [5:0] r_pre;
  logic [6:0] r_lfo;
  logic [7:0] r_trem;
  logic [4:0] r_am;
  logic       w_tick;
  logic       w_step;
  logic       w_hold;
  logic [6:0] w_lvl;
  logic [4:0] w_am;

`ifdef JTOPL_LFO_TEST_EN
  assign w_hold = lfo_rst;
`else
  logic w_unused_lfo_rst;
  assign w_unused_lfo_rst = lfo_rst;
  assign w_hold = 1'b0;
`endif

  assign w_tick = cenop & zero;
  assign w_step = w_tick && (r_pre == 6'(PRESCALE - 1));

  // Triangle folded around trem=105; trem never exceeds 209 so 210-trem fits 7 bits.
  assign w_lvl = (r_trem <= 8'd105) ? r_trem[6:0] : 7'(8'd210 - r_trem);
  assign w_am  = am_dep ? w_lvl[6:2] : {2'b00, w_lvl[6:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= 6'd0;
      r_lfo  <= 7'd0;
      r_trem <= 8'd0;
      r_am   <= 5'd0;
    end else if (cenop) begin
      r_am <= w_am;
      if (w_hold) begin
        r_pre  <= 6'd0;
        r_lfo  <= 7'd0;
        r_trem <= 8'd0;
      end else if (w_tick) begin
        r_pre <= w_step ? 6'd0 : r_pre + 6'd1;
        if (w_step) begin
          r_lfo  <= r_lfo + 7'd1;
          r_trem <= (r_trem == 8'd209) ? 8'd0 : r_trem + 8'd1;
        end
      end
    end
  end

  assign lfo_mod = r_lfo;
  assign am      = r_am;

endmodule

// File: tb/tb_jtopl_lfo.sv
// tb/tb_jtopl_lfo.sv - self-checking bench for jtopl_lfo against a tick-count reference model.
module tb_jtopl_lfo;

  localparam int P = 64;
`ifdef JTOPL_LFO_TEST_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cenop, zero, am_dep, lfo_rst;
  logic [6:0] lfo_mod;
  logic [4:0] am;

  jtopl_lfo #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .am_dep(am_dep),
    .lfo_rst(lfo_rst), .lfo_mod(lfo_mod), .am(am)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  // Model: frame ticks since last clear; every counter is derived from it.
  int n = 0;
  int m_am = 0;

  typedef struct {
    int ticks;
    int exp_lfo;
    int exp_am;
  } vec_t;
  vec_t tbl[12];

  function automatic int am_of(input int trem, input bit dep);
    int lvl;
    lvl = (trem <= 105) ? trem : 210 - trem;
    return dep ? (lvl / 4) : (lvl / 16);
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (ticks=%0d)", name, got, want, n);
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit z, input bit d, input bit l);
    rst = r; cenop = c; zero = z; am_dep = d; lfo_rst = l;
    @(posedge clk);
    if (r) begin
      n = 0;
      m_am = 0;
    end else if (c) begin
      m_am = am_of((n / P) % 210, d);
      if (HOLD_EN && l) n = 0;
      else if (z) n++;
    end
    #1;
    check("lfo_mod", int'(lfo_mod), (n / P) % 128);
    check("am", int'(am), m_am);
  endtask

  task automatic ticks_to(input int target, input bit d);
    while (n < target) cyc(1'b0, 1'b1, 1'b1, d, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{63,    0,   0};
    tbl[1]  = '{64,    1,   0};
    tbl[2]  = '{65,    1,   0};
    tbl[3]  = '{257,   4,   1};
    tbl[4]  = '{6720,  105, 26};
    tbl[5]  = '{6721,  105, 26};
    tbl[6]  = '{8128,  127, 21};
    tbl[7]  = '{8192,  0,   20};
    tbl[8]  = '{13000, 75,  1};
    tbl[9]  = '{13377, 81,  0};
    tbl[10] = '{13441, 82,  0};
    tbl[11] = '{13953, 90,  2};

    rst = 1'b1; cenop = 1'b0; zero = 1'b0; am_dep = 1'b0; lfo_rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_lfo", int'(lfo_mod), 0);
    check("reset_am", int'(am), 0);

    for (int i = 0; i < 12; i++) begin
      ticks_to(tbl[i].ticks, 1'b1);
      check($sformatf("tbl%0d_lfo", i), int'(lfo_mod), tbl[i].exp_lfo);
      check($sformatf("tbl%0d_am", i), int'(am), tbl[i].exp_am);
    end

    // Tremolo peak, then depth switch seen on the very next cenop edge.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks_to(6721, 1'b1);
    check("peak_am_dep1", int'(am), 26);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("peak_am_dep0", int'(am), 6);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("hold_cenop0_am", int'(am), 6);
    check("hold_cenop0_lfo", int'(lfo_mod), 105);

    // lfo_rst on a tick that is also a step, at lfo_mod=37.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks_to(38 * P - 1, 1'b1);
    check("pre_lforst_lfo", int'(lfo_mod), 37);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("lforst_lfo", int'(lfo_mod), HOLD_EN ? 0 : 38);
    if (HOLD_EN) begin
      for (int k = 0; k < P - 1; k++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("lforst_63_lfo", int'(lfo_mod), 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("lforst_64_lfo", int'(lfo_mod), 1);
    end

    // rst with cenop=0 at trem=50 clears everything and restarts cleanly.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks_to(50 * P + 1, 1'b1);
    check("pre_rst_am", int'(am), 12);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("midrst_lfo", int'(lfo_mod), 0);
    check("midrst_am", int'(am), 0);
    ticks_to(P - 1, 1'b1);
    check("midrst_63_lfo", int'(lfo_mod), 0);
    ticks_to(P, 1'b1);
    check("midrst_64_lfo", int'(lfo_mod), 1);

    // Random enables, depth, test hold and occasional reset.
    for (int k = 0; k < 20000; k++)
      cyc(($urandom_range(0, 4999) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 599) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
